fir_tap_mac: RTL and testbench

//  Serial 64-tap FIR multiply-accumulate engine for one equalizer band. Consumes
//  the 6-bit tap index from the free-running tap counter (same clk_enable) and

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_sample_ring.sv | 24 ++
 rtl/fir_tap_mac.sv | 79 +++++++
 tb/tb_fir_tap_mac.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, FSM states and output rounding for the FIR tap MAC
package fir_pkg;
    localparam int DATA_W     = 16;
    localparam int COEFF_W    = 16;
    localparam int TAP_W      = 6;
    localparam int TAPS       = 2 ** TAP_W;
    localparam int PROD_W     = DATA_W + COEFF_W;
    localparam int ACC_W      = DATA_W + COEFF_W + TAP_W;
    localparam int COEFF_FRAC = 15;

    typedef enum logic [1:0] {SYNC, IDLE, RUN} state_e;

    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2 ** (COEFF_FRAC - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

    function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W-1:0] r;
        r = (s + RND_HALF) >>> COEFF_FRAC;
        return r > SAT_MAX ? SAT_MAX[DATA_W-1:0] : r < SAT_MIN ? SAT_MIN[DATA_W-1:0] : r[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/fir_sample_ring.sv
// fir_sample_ring: 64-deep sample history; writes land one past head, reads look back tap_i
module fir_sample_ring
    import fir_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [TAP_W-1:0]         head_i,
    input  logic signed [DATA_W-1:0] wdata_i,
    input  logic [TAP_W-1:0]         tap_i,
    output logic signed [DATA_W-1:0] rdata_o
);
    logic signed [DATA_W-1:0] mem_q [TAPS];
    logic [TAP_W-1:0] waddr, raddr;

    assign waddr   = head_i + TAP_W'(1);
    assign raddr   = head_i - tap_i;
    assign rdata_o = mem_q[raddr];

    always_ff @(posedge clk) begin
        if (rst) mem_q <= '{default: '0};
        else if (we_i) mem_q[waddr] <= wdata_i;
    end
endmodule

// File: rtl/fir_tap_mac.sv
// fir_tap_mac: serial 64-tap FIR MAC, one tap per enabled cycle, one output per frame
module fir_tap_mac
    import fir_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_enable,
    input  logic [TAP_W-1:0]          tap_index,
    input  logic signed [DATA_W-1:0]  in_sample,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [TAP_W-1:0]          coeff_addr,
    input  logic signed [COEFF_W-1:0] coeff_data,
    output logic signed [DATA_W-1:0]  out_sample,
    output logic                      out_valid
);
    state_e state_q, state_d;
    logic pend_full_q, pend_full_d, out_valid_q;
    logic signed [DATA_W-1:0] pend_q, pend_d, out_q, out_d, ring_x, x;
    logic [TAP_W-1:0] head_q, head_d;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, sum;
    logic frame_edge, start, flush, mac, load;

    assign frame_edge = clk_enable && tap_index == '0;
    assign start      = frame_edge && pend_full_q;
    assign flush      = frame_edge && state_q == RUN;
    assign mac        = clk_enable && !frame_edge && state_q == RUN;
    assign load       = in_valid && !pend_full_q;
    assign sum        = acc_q + ACC_W'(prod_q);
    assign in_ready   = !pend_full_q;
    assign coeff_addr = tap_index;
    assign out_sample = out_q;
    assign out_valid  = out_valid_q;

    fir_sample_ring u_ring (
        .clk     (clk),
        .rst     (rst),
        .we_i    (start),
        .head_i  (head_q),
        .wdata_i (pend_q),
        .tap_i   (tap_index),
        .rdata_o (ring_x)
    );

    // tap 0 takes the new sample straight from pending; the ring write lands the same edge
    always_comb begin
        x           = start ? pend_q : ring_x;
        state_d     = frame_edge ? (pend_full_q ? RUN : IDLE) : state_q;
        pend_full_d = load || (pend_full_q && !frame_edge);
        pend_d      = load ? in_sample : pend_q;
        head_d      = start ? head_q + TAP_W'(1) : head_q;
        prod_d      = (start || mac) ? PROD_W'(x) * PROD_W'(coeff_data) : prod_q;
        acc_d       = frame_edge ? '0 : mac ? sum : acc_q;
        out_d       = flush ? round_sat(sum) : out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SYNC;
            pend_full_q <= 1'b0;
            pend_q      <= '0;
            head_q      <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_full_q <= pend_full_d;
            pend_q      <= pend_d;
            head_q      <= head_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= flush;
        end
    end
endmodule

// File: tb/tb_fir_tap_mac.sv
// tb_fir_tap_mac: directed vector tables plus reset/skip/gap sequences for fir_tap_mac
module tb_fir_tap_mac
    import fir_pkg::*;
;
    typedef struct {
        logic [15:0] sample;
        logic [15:0] exp_out;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, clk_enable = 1'b1, in_valid = 1'b0;
    logic in_ready, out_valid;
    logic [TAP_W-1:0] tap = '0, coeff_addr;
    logic signed [DATA_W-1:0] in_sample = '0, out_sample;
    logic signed [COEFF_W-1:0] coeff_data;
    bit coeff_max = 1'b0, gaps_on = 1'b0;
    int gap_left = 0;
    int n_pass = 0, n_total = 0;
    logic [15:0] got_q[$];
    vec_t vecs[128];

    fir_tap_mac dut (
        .clk        (clk),
        .rst        (rst),
        .clk_enable (clk_enable),
        .tap_index  (tap),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .coeff_addr (coeff_addr),
        .coeff_data (coeff_data),
        .out_sample (out_sample),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    // free-running tap counter sharing clk_enable, not touched by the block reset
    always @(posedge clk) if (clk_enable) tap <= tap + TAP_W'(1);

    assign coeff_data = coeff_max ? 16'sh7FFF : COEFF_W'(2 * (int'(coeff_addr) + 1));

    initial forever begin
        @(negedge clk);
        if (gap_left > 0) begin
            clk_enable = 1'b0;
            gap_left--;
        end else begin
            clk_enable = 1'b1;
            gap_left = gaps_on ? int'($urandom_range(0, 3)) : 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: got no DUT event, expected one within the cycle budget", name);
    endtask

    always @(negedge clk) if (out_valid) begin
        got_q.push_back(out_sample);
        chk("out_valid_after_tap0", 32'(tap), 32'd1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got_q.delete();
    endtask

    task automatic send(input logic [15:0] s);
        bit saw_low = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            in_sample = s;
            in_valid = 1'b1;
            if (!in_ready) saw_low = 1'b1;
            else begin
                if (saw_low) chk("in_ready_rise_tap", 32'(tap), 32'd1);
                @(posedge clk);
                @(negedge clk);
                chk("in_ready_after_load", 32'(in_ready), 32'd0);
                return;
            end
        end
        timeout("send");
    endtask

    task automatic wait_outputs(input int n);
        for (int i = 0; i < 2000 && got_q.size() < n; i++) @(negedge clk);
        if (got_q.size() < n) timeout($sformatf("outputs_%0d", n));
    endtask

    task automatic wait_tap(input int t);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (int'(tap) == t) return;
        end
        timeout($sformatf("tap_%0d", t));
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send(vecs[i].sample);
        in_valid = 1'b0;
    endtask

    task automatic cmp_range(input int lo, input int hi, input string name);
        for (int i = lo; i <= hi; i++)
            chk($sformatf("%s[%0d]", name, i), i < got_q.size() ? 32'(got_q[i]) : 'x, 32'(vecs[i].exp_out));
    endtask

    task automatic run_vecs(input int n, input string name);
        send_range(0, n - 1);
        wait_outputs(n);
        chk($sformatf("%s_count", name), 32'(got_q.size()), 32'(n));
        cmp_range(0, n - 1, name);
    endtask

    task automatic fill_impulse(input int n);
        for (int i = 0; i < n; i++) begin
            vecs[i].sample  = i == 0 ? 16'h4000 : 16'h0000;
            vecs[i].exp_out = i < 64 ? 16'(i + 1) : 16'h0000;
        end
    endtask

    initial begin
        do_reset();
        chk("rst_out_sample", 32'(out_sample), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("coeff_addr", 32'(coeff_addr), 32'(tap));

        fill_impulse(70);
        run_vecs(70, "impulse");

        do_reset();
        vecs[0] = '{16'h2000, 16'h0001};
        vecs[1] = '{16'hC000, 16'h0000};
        vecs[2] = '{16'hFFFF, 16'hFFFF};
        run_vecs(3, "round");

        do_reset();
        fill_impulse(15);
        send_range(0, 9);
        wait_outputs(10);
        repeat (70) @(negedge clk);
        chk("skip_no_pulse", 32'(got_q.size()), 32'd10);
        send_range(10, 14);
        wait_outputs(15);
        cmp_range(0, 14, "skip");

        gaps_on = 1'b1;
        do_reset();
        fill_impulse(70);
        run_vecs(70, "gaps");
        gaps_on = 1'b0;

        coeff_max = 1'b1;
        do_reset();
        for (int m = 0; m < 128; m++) begin
            vecs[m].sample  = m < 64 ? 16'h7FFF : 16'h8000;
            vecs[m].exp_out = m == 0 ? 16'h7FFE : m <= 94 ? 16'h7FFF : m == 95 ? 16'hFFE0 : 16'h8000;
        end
        run_vecs(128, "sat");
        coeff_max = 1'b0;

        do_reset();
        vecs[0].exp_out = 16'h0001;
        vecs[1].exp_out = 16'h0001;
        send(16'h4000);
        send(16'h4000);
        in_valid = 1'b0;
        wait_outputs(1);
        cmp_range(0, 0, "pre_rst");
        wait_tap(30);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_sample", 32'(out_sample), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        send(16'h4000);
        in_valid = 1'b0;
        wait_tap(0);
        wait_tap(3);
        chk("abort_no_pulse", 32'(got_q.size()), 32'd1);
        wait_outputs(2);
        cmp_range(1, 1, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
